// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with run-time pattern, length and overlap mode.
// Optional saturating match counter enabled by defining SEQ_DET_PROG_COUNT_EN.
module seq_det_prog #(
  parameter int unsigned           MAX_LEN     = 8,
  parameter int unsigned           LEN_W       = 4,
  parameter logic [MAX_LEN-1:0]    RST_PATTERN = 8'b0000_1011,
  parameter int unsigned           RST_LEN     = 4
`ifdef SEQ_DET_PROG_COUNT_EN
  ,
  parameter int unsigned           CNT_W       = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               ov_mode_in,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               detect,
  output logic [LEN_W-1:0]   fill
`ifdef SEQ_DET_PROG_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_load;
  logic [LEN_W-1:0]   fill_next;
  logic               ov_q;
  logic               match;

  // Next history/fill and the match decision for the bit offered this cycle.
  always_comb begin
    len_load  = (32'(len_in) > MAX_LEN) ? LEN_W'(MAX_LEN) : len_in;
    hist_next = {hist_q[MAX_LEN-2:0], bit_in};
    fill_next = (fill < len_q) ? fill + 1'b1 : len_q;
    mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len_q)) mask[i] = 1'b1;
    end
    match = (len_q != '0) && (fill_next >= len_q) &&
            (((hist_next ^ pat_q) & mask) == '0);
  end

  // Configuration, history, fill and detect; load wins over a same-cycle bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= RST_PATTERN;
      len_q  <= LEN_W'(RST_LEN);
      ov_q   <= 1'b1;
      hist_q <= '0;
      fill   <= '0;
      detect <= 1'b0;
    end else if (load) begin
      pat_q  <= pattern_in;
      len_q  <= len_load;
      ov_q   <= ov_mode_in;
      hist_q <= '0;
      fill   <= '0;
      detect <= 1'b0;
    end else if (bit_valid) begin
      hist_q <= hist_next;
      fill   <= (match && !ov_q) ? '0 : fill_next;
      detect <= match;
    end else begin
      detect <= 1'b0;
    end
  end

`ifdef SEQ_DET_PROG_COUNT_EN
  // Counts detect pulses, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (load) begin
      match_cnt <= '0;
    end else if (bit_valid && match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: queue-based reference model compared every cycle, plus directed literal checks.
module tb_seq_det_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int          CNT_MAX = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load = 1'b0;
  logic [MAX_LEN-1:0] pattern_in = '0;
  logic [LEN_W-1:0]   len_in = '0;
  logic               ov_mode_in = 1'b0;
  logic               bit_valid = 1'b0;
  logic               bit_in = 1'b0;
  logic               detect;
  logic [LEN_W-1:0]   fill;
`ifdef SEQ_DET_PROG_COUNT_EN
  logic [1:0]         match_cnt;
`endif

  int tests = 0;
  int fails = 0;

  seq_det_prog #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RST_PATTERN(8'b0000_1011), .RST_LEN(4)
`ifdef SEQ_DET_PROG_COUNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .load(load), .pattern_in(pattern_in), .len_in(len_in),
    .ov_mode_in(ov_mode_in), .bit_valid(bit_valid), .bit_in(bit_in),
    .detect(detect), .fill(fill)
`ifdef SEQ_DET_PROG_COUNT_EN
    , .match_cnt(match_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: bits received since the last clear, newest at the back.
  int       m_q[$];
  logic [7:0] m_pat = 8'b0000_1011;
  int       m_len = 4;
  bit       m_ov  = 1'b1;
  int       m_det = 0;
  int       m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pat = 8'b0000_1011; m_len = 4; m_ov = 1'b1; m_det = 0; m_cnt = 0;
    end else if (load) begin
      m_pat = pattern_in;
      m_len = (int'(len_in) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(len_in);
      m_ov  = ov_mode_in;
      m_q.delete();
      m_det = 0; m_cnt = 0;
    end else if (bit_valid) begin
      bit ok;
      m_q.push_back(int'(bit_in));
      if (m_q.size() > int'(MAX_LEN)) void'(m_q.pop_front());
      ok = (m_len != 0) && (m_q.size() >= m_len);
      if (ok) begin
        for (int k = 0; k < m_len; k++)
          if (m_q[m_q.size()-1-k] != int'(m_pat[k])) ok = 1'b0;
      end
      m_det = ok ? 1 : 0;
      if (ok && !m_ov) m_q.delete();
      if (ok && m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_det = 0;
    end
  end

  function automatic int m_fill();
    return (m_q.size() < m_len) ? m_q.size() : m_len;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    tests++;
    if (int'(detect) != m_det || int'(fill) != m_fill()) begin
      fails++;
      $display("FAIL model_cmp t=%0t: detect=%0d fill=%0d, expected detect=%0d fill=%0d",
               $time, detect, fill, m_det, m_fill());
    end
`ifdef SEQ_DET_PROG_COUNT_EN
    tests++;
    if (int'(match_cnt) != m_cnt) begin
      fails++;
      $display("FAIL model_cnt t=%0t: match_cnt=%0d expected %0d", $time, match_cnt, m_cnt);
    end
`endif
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic b);
    @(negedge clk); load = 1'b0; bit_valid = 1'b1; bit_in = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); load = 1'b0; bit_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Load with a competing valid bit that must be dropped.
  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    @(negedge clk);
    load = 1'b1; pattern_in = p; len_in = l; ov_mode_in = ov; bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk); #1;
    chk("load_fill", int'(fill), 0);
    chk("load_detect", int'(detect), 0);
    @(negedge clk); load = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst = 1'b1; bit_valid = 1'b0; load = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s1[7]   = '{1, 0, 1, 1, 0, 1, 1};
    int e_ov[7] = '{0, 0, 0, 1, 0, 0, 1};
    int e_no[7] = '{0, 0, 0, 1, 0, 0, 0};
    int f_no[7] = '{1, 2, 3, 0, 1, 2, 3};
    int ndet;
    logic [7:0] p;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_detect", int'(detect), 0);
    chk("reset_fill", int'(fill), 0);
    @(negedge clk); rst = 1'b0;

    // Reset defaults: 1011 overlapping.
    for (int i = 0; i < 7; i++) begin
      step(s1[i] != 0);
      chk($sformatf("ov_det_%0d", i), int'(detect), e_ov[i]);
      if (i == 3) chk("ov_fill_4", int'(fill), 4);
    end
    idle(1);
    chk("ov_idle_det", int'(detect), 0);

    // Same pattern, non-overlapping.
    do_load(8'b0000_1011, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(s1[i] != 0);
      chk($sformatf("nov_det_%0d", i), int'(detect), e_no[i]);
      chk($sformatf("nov_fill_%0d", i), int'(fill), f_no[i]);
    end
    idle(1);

    // Full-length pattern with valid gaps.
    p = 8'b1100_1010;
    do_load(p, 4'd8, 1'b1);
    ndet = 0;
    for (int i = 7; i >= 0; i--) begin
      step(p[i]);
      ndet += int'(detect);
      if (i == 0) chk("gap_final_det", int'(detect), 1);
      for (int g = 0; g < (i % 3) + 1; g++) begin
        idle(1);
        ndet += int'(detect);
      end
    end
    chk("gap_det_count", ndet, 1);

    // Length 0 disables detection.
    do_load(8'hFF, 4'd0, 1'b1);
    ndet = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)));
      ndet += int'(detect);
    end
    chk("len0_det_count", ndet, 0);
    chk("len0_fill", int'(fill), 0);
    idle(1);

    // Length 12 clamps to 8.
    p = 8'b1011_0011;
    do_load(p, 4'd12, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      step(p[i]);
      chk($sformatf("clamp_det_%0d", i), int'(detect), (i == 0) ? 1 : 0);
    end
    chk("clamp_fill", int'(fill), 8);
    idle(1);

    // Asynchronous reset mid-stream loses the partial match.
    reset_pulse();
    step(1'b1); step(1'b0); step(1'b1);
    chk("pre_rst_fill", int'(fill), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_fill", int'(fill), 0);
    chk("async_rst_det", int'(detect), 0);
    @(negedge clk); rst = 1'b0; bit_valid = 1'b0;
    step(1'b1);
    chk("post_rst_det", int'(detect), 0);
    chk("post_rst_fill", int'(fill), 1);
    idle(1);

    // Pattern 11, overlapping: back-to-back detects and counter saturation.
    do_load(8'b0000_0011, 4'd2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      chk($sformatf("b2b_det_%0d", i), int'(detect), (i == 0) ? 0 : 1);
`ifdef SEQ_DET_PROG_COUNT_EN
      if (i > 0) chk($sformatf("cnt_%0d", i), int'(match_cnt), (i > 3) ? 3 : i);
`endif
    end
    idle(1);
`ifdef SEQ_DET_PROG_COUNT_EN
    do_load(8'b0000_0011, 4'd2, 1'b1);
    #1;
    chk("cnt_after_load", int'(match_cnt), 0);
`endif
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
